// File: rtl/rgmii_pkg.sv
// Shared types for the RGMII/UDP TX source scheduler: FSM states, header request
// fields and the default inter-frame gap.
package rgmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_PAD,
    ST_DROP,
    ST_GAP
  } state_t;

  localparam int IFG_DEFAULT = 12;

  typedef struct packed {
    logic [15:0] port;
    logic [15:0] len;
  } hdr_t;

  // Index of the (single) set bit of a one-hot vector of up to 8 sources.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the source after the last one
// committed through upd_en_i; after reset source 0 has highest priority.
module rr_arbiter
  import rgmii_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  input  logic         soft_rst_i,
  input  logic [N-1:0] req_i,
  input  logic         upd_en_i,
  input  logic [N-1:0] upd_gnt_i,
  output logic [N-1:0] gnt_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] start_q;
  logic [IW-1:0] upd_idx;
  logic [IW-1:0] idx;
  logic          found;

  assign upd_idx = IW'(oh2idx(8'(upd_gnt_i)));

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(start_q) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      start_q <= '0;
    end else if (soft_rst_i) begin
      start_q <= '0;
    end else if (upd_en_i) begin
      start_q <= (upd_idx == IW'(N - 1)) ? '0 : upd_idx + IW'(1);
    end
  end

endmodule

// File: rtl/rgmii_tx_sched.sv
// Schedules N_SRC byte sources onto one UDP TX payload stream: round-robin grant,
// header request, exact-length framing with zero pad / truncation, and an IFG.
module rgmii_tx_sched
  import rgmii_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int IFG_CYCLES = IFG_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   soft_rst_i,
  input  logic [15:0]            payload_bytes_i,
  input  logic [N_SRC-1:0][15:0] src_port_i,
  input  logic [N_SRC-1:0][7:0]  s_tdata_i,
  input  logic [N_SRC-1:0]       s_tvalid_i,
  input  logic [N_SRC-1:0]       s_tlast_i,
  output logic [N_SRC-1:0]       s_tready_o,
  output logic                   hdr_valid_o,
  input  logic                   hdr_ready_i,
  output logic [15:0]            hdr_port_o,
  output logic [15:0]            hdr_len_o,
  output logic [7:0]             m_tdata_o,
  output logic                   m_tvalid_o,
  output logic                   m_tlast_o,
  input  logic                   m_tready_i,
  output logic [N_SRC-1:0]       grant_o,
  output logic                   pad_evt_o,
  output logic                   trunc_evt_o,
  output logic                   busy_o,
  output state_t                 dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never drops and data never changes while valid waits for ready.

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t           state_q, state_n;
  hdr_t             hdr_q, hdr_n;
  logic [15:0]      cnt_q, cnt_n;
  logic [N_SRC-1:0] grant_q, grant_n;
  logic [IW-1:0]    gidx_q, gidx_n;
  logic [N_SRC-1:0] arb_gnt;
  logic             arb_upd;
  logic             last_beat;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .soft_rst_i (soft_rst_i),
    .req_i      (s_tvalid_i),
    .upd_en_i   (arb_upd),
    .upd_gnt_i  (grant_q),
    .gnt_o      (arb_gnt)
  );

  assign last_beat   = (cnt_q == hdr_q.len - 16'd1);
  assign arb_upd     = (state_q != ST_GAP) && (state_n == ST_GAP);
  assign hdr_port_o  = hdr_q.port;
  assign hdr_len_o   = hdr_q.len;
  assign grant_o     = (state_q == ST_IDLE) ? '0 : grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

  always_comb begin
    state_n     = state_q;
    hdr_n       = hdr_q;
    cnt_n       = cnt_q;
    grant_n     = grant_q;
    gidx_n      = gidx_q;
    s_tready_o  = '0;
    hdr_valid_o = 1'b0;
    m_tdata_o   = '0;
    m_tvalid_o  = 1'b0;
    m_tlast_o   = 1'b0;
    pad_evt_o   = 1'b0;
    trunc_evt_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|s_tvalid_i && payload_bytes_i != 16'd0) begin
          grant_n    = arb_gnt;
          gidx_n     = IW'(oh2idx(8'(arb_gnt)));
          hdr_n.port = src_port_i[gidx_n];
          hdr_n.len  = payload_bytes_i;
          cnt_n      = '0;
          state_n    = ST_HDR;
        end
      end
      ST_HDR: begin
        hdr_valid_o = 1'b1;
        if (hdr_ready_i) begin
          cnt_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        m_tdata_o          = s_tdata_i[gidx_q];
        m_tvalid_o         = s_tvalid_i[gidx_q];
        m_tlast_o          = s_tvalid_i[gidx_q] & last_beat;
        s_tready_o[gidx_q] = m_tready_i;
        if (s_tvalid_i[gidx_q] && m_tready_i) begin
          if (last_beat) begin
            cnt_n = '0;
            if (s_tlast_i[gidx_q]) begin
              state_n = ST_GAP;
            end else begin
              trunc_evt_o = 1'b1;
              state_n     = ST_DROP;
            end
          end else begin
            cnt_n = cnt_q + 16'd1;
            if (s_tlast_i[gidx_q]) begin
              pad_evt_o = 1'b1;
              state_n   = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        m_tvalid_o = 1'b1;
        m_tlast_o  = last_beat;
        if (m_tready_i) begin
          if (last_beat) begin
            cnt_n   = '0;
            state_n = ST_GAP;
          end else begin
            cnt_n = cnt_q + 16'd1;
          end
        end
      end
      ST_DROP: begin
        // Source is drained so it can start its next packet cleanly.
        s_tready_o[gidx_q] = 1'b1;
        if (s_tvalid_i[gidx_q] && s_tlast_i[gidx_q]) begin
          cnt_n   = '0;
          state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == 16'(IFG_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      gidx_q  <= '0;
    end else if (soft_rst_i) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_n;
      hdr_q   <= hdr_n;
      cnt_q   <= cnt_n;
      grant_q <= grant_n;
      gidx_q  <= gidx_n;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_sched.sv
// Directed bench for rgmii_tx_sched: frame-level model (RR winner, exact-length
// byte image, gap length) plus literal checks on each scenario.
module tb_rgmii_tx_sched;
  import rgmii_pkg::*;

  localparam int N   = 4;
  localparam int IFG = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  logic              soft_rst = 1'b0;
  logic [15:0]       payload = '0;
  logic [N-1:0][15:0] src_port;
  logic [N-1:0][7:0] s_tdata = '0;
  logic [N-1:0]      s_tvalid = '0;
  logic [N-1:0]      s_tlast = '0;
  logic [N-1:0]      s_tready;
  logic              hdr_valid;
  logic              hdr_ready = 1'b1;
  logic [15:0]       hdr_port, hdr_len;
  logic [7:0]        m_tdata;
  logic              m_tvalid, m_tlast;
  logic              m_tready = 1'b1;
  logic [N-1:0]      grant;
  logic              pad_evt, trunc_evt, busy;
  state_t            dbg_state;

  rgmii_tx_sched #(.N_SRC(N), .IFG_CYCLES(IFG)) dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .soft_rst_i      (soft_rst),
    .payload_bytes_i (payload),
    .src_port_i      (src_port),
    .s_tdata_i       (s_tdata),
    .s_tvalid_i      (s_tvalid),
    .s_tlast_i       (s_tlast),
    .s_tready_o      (s_tready),
    .hdr_valid_o     (hdr_valid),
    .hdr_ready_i     (hdr_ready),
    .hdr_port_o      (hdr_port),
    .hdr_len_o       (hdr_len),
    .m_tdata_o       (m_tdata),
    .m_tvalid_o      (m_tvalid),
    .m_tlast_o       (m_tlast),
    .m_tready_i      (m_tready),
    .grant_o         (grant),
    .pad_evt_o       (pad_evt),
    .trunc_evt_o     (trunc_evt),
    .busy_o          (busy),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [8:0] src_q [0:N-1][$];
  logic [8:0] exp_q[$];
  logic [8:0] out_log[$];
  logic [3:0] grant_log[$];

  int   last_src = N - 1;
  int   cur_src = 0;
  int   cur_len = 0;
  bit   frame_trunc = 1'b0;
  bit   gap_armed = 1'b0;
  int   gap_cnt = 0;
  bit   prev_busy = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [N-1:0] cand_valid = '0;
  logic [15:0] cand_len = '0;
  int   beats = 0;
  int   act_pad = 0, act_trunc = 0, exp_pad = 0, exp_trunc = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: pick the RR winner, build the exact-length byte image.
  task automatic start_frame();
    int w;
    int k;
    bit done;
    logic [8:0] tmp;
    logic [8:0] pkt[$];
    w = -1;
    for (int i = 1; i <= N; i++) begin
      if (w < 0 && cand_valid[(last_src + i) % N]) w = (last_src + i) % N;
    end
    if (w < 0) begin
      chk("start_without_request", 32'(busy), 32'd0);
      return;
    end
    done = 1'b0;
    for (int j = 0; j < src_q[w].size() && !done; j++) begin
      tmp = src_q[w][j];
      pkt.push_back(tmp);
      if (tmp[8]) done = 1'b1;
    end
    k = pkt.size();
    for (int j = 0; j < int'(cand_len); j++) begin
      tmp = (j < k) ? pkt[j] : 9'h000;
      exp_q.push_back({(j == int'(cand_len) - 1), tmp[7:0]});
    end
    if (k < int'(cand_len)) exp_pad++;
    if (k > int'(cand_len)) exp_trunc++;
    cur_src     = w;
    cur_len     = int'(cand_len);
    frame_trunc = (k > int'(cand_len));
    last_src    = w;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (!arstn) begin
      prev_busy  = 1'b0;
      prev_stall = 1'b0;
    end else if (soft_rst) begin
      exp_q.delete();
      gap_armed   = 1'b0;
      frame_trunc = 1'b0;
      last_src    = N - 1;
      prev_stall  = 1'b0;
      prev_busy   = busy;
    end else begin
      if (!prev_busy && busy) start_frame();
      if (!busy) begin
        cand_valid = s_tvalid;
        cand_len   = payload;
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_ready", 32'(s_tready), 32'd0);
        chk("idle_mvalid", 32'(m_tvalid), 32'd0);
      end
      if (gap_armed) begin
        if (busy) begin
          gap_cnt++;
          chk("gap_ready", 32'(s_tready), 32'd0);
          chk("gap_mvalid", 32'(m_tvalid), 32'd0);
        end else begin
          chk("gap_len", 32'(gap_cnt), 32'(IFG));
          gap_armed = 1'b0;
        end
      end
      if (hdr_valid && hdr_ready) begin
        chk("hdr_port", 32'(hdr_port), 32'(src_port[cur_src]));
        chk("hdr_len", 32'(hdr_len), 32'(cur_len));
        chk("hdr_grant", 32'(grant), 32'(1 << cur_src));
        grant_log.push_back(grant);
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk("hold_data", 32'(m_tdata), 32'(prev_data));
      end
      if (m_tvalid && m_tready) begin
        beats++;
        out_log.push_back({m_tlast, m_tdata});
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {23'd0, m_tlast, m_tdata}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({m_tlast, m_tdata}), 32'(e));
          if (e[8] && !frame_trunc) begin
            gap_armed = 1'b1;
            gap_cnt   = 0;
          end
        end
      end
      act_pad   += int'(pad_evt);
      act_trunc += int'(trunc_evt);
      prev_busy  = busy;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
    // Source-side handshakes consume bytes from the source queues.
    for (int i = 0; i < N; i++) begin
      if (arstn && s_tvalid[i] && s_tready[i] && src_q[i].size() > 0) begin
        e = src_q[i].pop_front();
        if (!soft_rst && e[8] && frame_trunc && i == cur_src) begin
          gap_armed   = 1'b1;
          gap_cnt     = 0;
          frame_trunc = 1'b0;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    logic [8:0] h;
    #2;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[i]  = h[7:0];
        s_tlast[i]  = h[8];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i]  = '0;
        s_tlast[i]  = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_pkt(input int src, input logic [7:0] first, input int n);
    for (int j = 0; j < n; j++) src_q[src].push_back({(j == n - 1), first + 8'(j)});
  endtask

  task automatic clear_logs();
    out_log.delete();
    grant_log.delete();
    beats     = 0;
    act_pad   = 0;
    act_trunc = 0;
    exp_pad   = 0;
    exp_trunc = 0;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!(!busy && exp_q.size() == 0 && !gap_armed && queues_empty()) && t < 3000);
    if (t >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: busy=%0d exp_left=%0d", tag, busy, exp_q.size());
    end
  endtask

  task automatic wait_busy(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!busy && t < 50);
    chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (beats < n && t < 200);
    chk("beats_wait", 32'(beats >= n), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    for (int i = 0; i < N; i++) src_port[i] = 16'hC000 + 16'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    chk("rst_hdr_port", 32'(hdr_port), 32'd0);
    chk("rst_hdr_len", 32'(hdr_len), 32'd0);
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_mlast", 32'(m_tlast), 32'd0);
    chk("rst_sready", 32'(s_tready), 32'd0);
    chk("rst_events", 32'({pad_evt, trunc_evt}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1 arstn = 1'b1;

    // Zero payload length keeps the block idle even with a request pending.
    push_pkt(1, 8'h01, 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_sready", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1 src_q[1].delete();
    repeat (2) @(posedge clk);
    #1 clear_logs();

    // Two simultaneous requesters, len 4: source 0 then source 2.
    payload = 16'd4;
    push_pkt(0, 8'h10, 4);
    push_pkt(2, 8'h20, 4);
    wait_done("rr");
    chk("rr_frames", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("rr_grant0", 32'(grant_log[0]), 32'h1);
      chk("rr_grant1", 32'(grant_log[1]), 32'h4);
    end
    chk("rr_bytes", 32'(out_log.size()), 32'd8);
    if (out_log.size() == 8) begin
      chk("rr_last0", 32'(out_log[3]), 32'h113);
      chk("rr_first1", 32'(out_log[4]), 32'h020);
    end
    chk("rr_pad_model", 32'(act_pad), 32'(exp_pad));
    clear_logs();

    // Short packet, len 5: AA BB then three pad bytes.
    payload = 16'd5;
    src_q[1].push_back(9'h0AA);
    src_q[1].push_back(9'h1BB);
    wait_done("pad");
    chk("pad_bytes", 32'(out_log.size()), 32'd5);
    if (out_log.size() == 5) begin
      chk("pad_b0", 32'(out_log[0]), 32'h0AA);
      chk("pad_b1", 32'(out_log[1]), 32'h0BB);
      chk("pad_b2", 32'(out_log[2]), 32'h000);
      chk("pad_b4", 32'(out_log[4]), 32'h100);
    end
    chk("pad_evt_count", 32'(act_pad), 32'd1);
    chk("pad_trunc_count", 32'(act_trunc), 32'd0);
    clear_logs();

    // Long packet, len 4: four bytes out, remaining four dropped.
    payload = 16'd4;
    push_pkt(3, 8'h30, 8);
    wait_done("trunc");
    chk("trunc_bytes", 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) chk("trunc_last", 32'(out_log[3]), 32'h133);
    chk("trunc_evt_count", 32'(act_trunc), 32'd1);
    chk("trunc_model", 32'(act_trunc), 32'(exp_trunc));
    chk("trunc_src_drained", 32'(src_q[3].size()), 32'd0);
    clear_logs();

    // Header backpressure: hdr_ready low for 10 cycles.
    hdr_ready = 1'b0;
    payload   = 16'd3;
    push_pkt(1, 8'h40, 3);
    wait_busy("hdr");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("hdr_hold_valid", 32'(hdr_valid), 32'd1);
      chk("hdr_hold_port", 32'(hdr_port), 32'hC001);
      chk("hdr_hold_len", 32'(hdr_len), 32'd3);
      chk("hdr_hold_nodata", 32'(m_tvalid), 32'd0);
    end
    @(posedge clk);
    #1 hdr_ready = 1'b1;
    wait_done("hdr");
    chk("hdr_bytes", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) chk("hdr_first", 32'(out_log[0]), 32'h040);
    clear_logs();

    // Random downstream stalls; length change mid-frame must be ignored.
    payload    = 16'd16;
    rand_ready = 1'b1;
    push_pkt(0, 8'h50, 16);
    wait_busy("stall");
    @(posedge clk);
    #1 payload = 16'd3;
    wait_done("stall");
    rand_ready = 1'b0;
    @(posedge clk);
    #1 m_tready = 1'b1;
    chk("stall_bytes", 32'(out_log.size()), 32'd16);
    if (out_log.size() == 16) chk("stall_last", 32'(out_log[15]), 32'h15F);
    clear_logs();

    // Soft reset mid-frame, then source 0 must win over source 3.
    payload = 16'd10;
    push_pkt(2, 8'h60, 10);
    wait_beats(3);
    @(posedge clk);
    #1 soft_rst = 1'b1;
    @(posedge clk);
    #1 soft_rst = 1'b0;
    src_q[2].delete();
    @(negedge clk);
    #1;
    chk("srst_busy", 32'(busy), 32'd0);
    chk("srst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("srst_grant", 32'(grant), 32'd0);
    chk("srst_mvalid", 32'({m_tvalid, m_tlast}), 32'd0);
    chk("srst_hdr", 32'({hdr_port, hdr_len}), 32'd0);
    chk("srst_sready", 32'(s_tready), 32'd0);
    clear_logs();
    payload = 16'd2;
    push_pkt(0, 8'h70, 2);
    push_pkt(3, 8'h80, 2);
    wait_done("srst");
    chk("srst_frames", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("srst_grant0", 32'(grant_log[0]), 32'h1);
      chk("srst_grant1", 32'(grant_log[1]), 32'h8);
    end
    if (out_log.size() > 0) chk("srst_first", 32'(out_log[0]), 32'h070);
    else chk("srst_out_count", 32'(out_log.size()), 32'd4);

    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
